// File: rtl/irq_ctrl_nest.sv
// irq_ctrl_nest: nested priority interrupt controller with a hardware priority/index stack and MMIO registers.
// Define IRQ_CTRL_EDGE_EN for rising-edge source latching; the default build latches on level.
module irq_ctrl_nest #(
  parameter int          NUM_SRC      = 8,
  parameter int          NEST_DEPTH   = 4,
  parameter logic [15:0] VEC_STRIDE   = 16'h0020,
  parameter logic [15:0] VEC_BASE_RST = 16'h0020
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sel,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [2:0]         i_addr,
  input  logic [15:0]        i_wdata,
  output logic [15:0]        o_rdata,
  output logic               o_rdy,
  input  logic [NUM_SRC-1:0] i_src_irq,
  input  logic               i_int_en,
  input  logic               i_irq_ret,
  output logic               o_irq_take,
  output logic [15:0]        o_irq_vector
);

  localparam logic [15:0] SRC_MASK  = 16'((32'd1 << NUM_SRC) - 32'd1);
  localparam logic [31:0] PRIO_MASK = 32'((64'd1 << (2 * NUM_SRC)) - 64'd1);
  localparam logic [3:0]  DEPTH_MAX = 4'(NEST_DEPTH);

  localparam logic [2:0] A_PEND   = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_CLEAR  = 3'd2;
  localparam logic [2:0] A_PRIO0  = 3'd3;
  localparam logic [2:0] A_PRIO1  = 3'd4;
  localparam logic [2:0] A_ACTIVE = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_VBASE  = 3'd7;

  logic [15:0] pend, mask, active, vbase;
  logic [31:0] prio;
  logic [3:0]  depth;
  logic [3:0]  stk_idx [8];
  logic [1:0]  stk_pri [8];
  logic [15:0] rdata_p1;

  logic [15:0] src_vec, set_now, pend_now, elig;
  logic [15:0] pend_next, active_next, rd_val;
  logic [3:0]  sel_idx, depth_eff, depth_next, stat_idx;
  logic [1:0]  sel_pri, cur_pri, stat_pri;
  logic        any_elig, ret_ok, take, wr;
  logic [2:0]  top, top_eff;

  assign src_vec = 16'(i_src_irq);
  assign wr      = i_sel & i_we;

`ifdef IRQ_CTRL_EDGE_EN
  logic [15:0] src_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) src_prev <= '0;
    else       src_prev <= src_vec;
  end

  assign set_now = src_vec & ~src_prev & ~active;
`else
  assign set_now = src_vec & ~active;
`endif

  // Sources latched this cycle already compete, giving zero-cycle source-to-take latency.
  assign pend_now = pend | set_now;
  assign elig     = pend_now & mask & ~active;
  assign any_elig = |elig;

  always_comb begin
    sel_idx = '0;
    sel_pri = '0;
    for (int k = 0; k < 16; k++) begin
      if (elig[k] && (prio[2*k +: 2] >= sel_pri)) begin
        sel_idx = 4'(k);
        sel_pri = prio[2*k +: 2];
      end
    end
  end

  assign ret_ok    = i_irq_ret & (depth != 4'd0);
  assign depth_eff = depth - {3'b000, ret_ok};
  assign top_eff   = 3'(depth_eff - 4'd1);
  assign cur_pri   = (depth_eff == 4'd0) ? 2'd0 : stk_pri[top_eff];

  assign take = any_elig & i_int_en
              & ((depth_eff == 4'd0) | (sel_pri > cur_pri))
              & (depth_eff < DEPTH_MAX);

  assign o_irq_take   = take;
  assign o_irq_vector = take ? (vbase + 16'(sel_idx) * VEC_STRIDE) : 16'hFFFF;
  assign o_rdy        = i_sel;
  assign o_rdata      = rdata_p1;

  assign top      = 3'(depth - 4'd1);
  assign stat_pri = (depth == 4'd0) ? 2'd0 : stk_pri[top];
  assign stat_idx = (depth == 4'd0) ? 4'd0 : stk_idx[top];

  // Precedence: source/PEND set, then CLEAR, then the take's own clear.
  always_comb begin
    pend_next = pend_now;
    if (wr && (i_addr == A_PEND))  pend_next = pend_next | (i_wdata & SRC_MASK);
    if (wr && (i_addr == A_CLEAR)) pend_next = pend_next & ~i_wdata;
    if (take)                      pend_next[sel_idx] = 1'b0;

    active_next = active;
    if (ret_ok) active_next[stk_idx[top]] = 1'b0;
    if (take)   active_next[sel_idx] = 1'b1;

    depth_next = depth_eff + {3'b000, take};
  end

  always_comb begin
    rd_val = '0;
    case (i_addr)
      A_PEND:   rd_val = pend;
      A_MASK:   rd_val = mask;
      A_CLEAR:  rd_val = '0;
      A_PRIO0:  rd_val = prio[15:0];
      A_PRIO1:  rd_val = prio[31:16];
      A_ACTIVE: rd_val = active;
      A_STATUS: rd_val = {6'b0, stat_idx, stat_pri, depth};
      A_VBASE:  rd_val = vbase;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend     <= '0;
      mask     <= SRC_MASK;
      active   <= '0;
      prio     <= '0;
      vbase    <= VEC_BASE_RST;
      depth    <= '0;
      rdata_p1 <= '0;
      for (int i = 0; i < 8; i++) begin
        stk_idx[i] <= '0;
        stk_pri[i] <= '0;
      end
    end else begin
      pend   <= pend_next;
      active <= active_next;
      depth  <= depth_next;
      if (take) begin
        stk_idx[3'(depth_eff)] <= sel_idx;
        stk_pri[3'(depth_eff)] <= sel_pri;
      end
      if (wr && (i_addr == A_MASK))  mask <= i_wdata & SRC_MASK;
      if (wr && (i_addr == A_PRIO0)) prio[15:0]  <= i_wdata & PRIO_MASK[15:0];
      if (wr && (i_addr == A_PRIO1)) prio[31:16] <= i_wdata & PRIO_MASK[31:16];
      if (wr && (i_addr == A_VBASE)) vbase <= i_wdata;
      // Read data register stage: valid one cycle after the read strobe, zero otherwise.
      rdata_p1 <= (i_sel && i_re) ? rd_val : 16'h0000;
    end
  end

endmodule

// File: tb/tb_irq_ctrl_nest.sv
// Testbench for irq_ctrl_nest: register table, directed nesting sequences and a randomized run against a queue-based model.
module tb_irq_ctrl_nest;

  localparam int          NSRC   = 8;
  localparam int          NDEPTH = 2;
  localparam logic [15:0] STRIDE = 16'h0020;
  localparam logic [15:0] VBRST  = 16'h0020;
  localparam logic [15:0] SMASK  = 16'((32'd1 << NSRC) - 32'd1);

  logic            clk = 1'b0;
  logic            rst, sel, we, re, int_en, ret, rdy, take;
  logic [2:0]      addr;
  logic [15:0]     wdata, rdata, vec;
  logic [NSRC-1:0] src;

  irq_ctrl_nest #(
    .NUM_SRC(NSRC), .NEST_DEPTH(NDEPTH), .VEC_STRIDE(STRIDE), .VEC_BASE_RST(VBRST)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_we(we), .i_re(re), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_rdy(rdy), .i_src_irq(src),
    .i_int_en(int_en), .i_irq_ret(ret), .o_irq_take(take), .o_irq_vector(vec)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [2:0] a, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic mmio_rd(input logic [2:0] a, output logic [15:0] d);
    sel = 1'b1; re = 1'b1; addr = a;
    tick();
    sel = 1'b0; re = 1'b0;
    d = rdata;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    mmio_rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic take_chk(input string name, input logic exp_t, input logic [15:0] exp_v);
    #1;
    chk({name, "_take"}, take, exp_t);
    chk({name, "_vec"}, vec, exp_v);
  endtask

  typedef struct {
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [15:0] exp;
  } reg_vec_t;

  reg_vec_t tbl [14];

  // Behavioural reference model state
  typedef struct { int idx; int pri; } frame_t;
  frame_t      m_stk [$];
  bit   [15:0] m_pend, m_mask, m_act, m_prev, m_vbase;
  int          m_prio [16];
  logic [15:0] m_rd_exp;

  task automatic model_reset();
    m_stk.delete();
    m_pend = '0; m_mask = SMASK; m_act = '0; m_prev = '0; m_vbase = VBRST;
    for (int k = 0; k < 16; k++) m_prio[k] = 0;
    m_rd_exp = '0;
  endtask

  task automatic model_step();
    int          dep_eff, cur, win, wpri, d;
    bit          ret_ok, exp_take;
    bit   [15:0] now_p;
    logic [15:0] exp_vec, rv;
    frame_t      f;
    ret_ok  = ret && (m_stk.size() > 0);
    dep_eff = m_stk.size() - (ret_ok ? 1 : 0);
    cur     = (dep_eff == 0) ? 0 : m_stk[dep_eff-1].pri;
    now_p   = m_pend;
    for (int k = 0; k < NSRC; k++) begin
`ifdef IRQ_CTRL_EDGE_EN
      if (src[k] && !m_act[k] && !m_prev[k]) now_p[k] = 1'b1;
`else
      if (src[k] && !m_act[k]) now_p[k] = 1'b1;
`endif
    end
    win = -1; wpri = 0;
    for (int p = 3; p >= 0 && win < 0; p--)
      for (int k = NSRC - 1; k >= 0 && win < 0; k--)
        if (now_p[k] && m_mask[k] && !m_act[k] && m_prio[k] == p) begin
          win = k; wpri = p;
        end
    exp_take = (win >= 0) && int_en && (dep_eff == 0 || wpri > cur) && (dep_eff < NDEPTH);
    exp_vec  = exp_take ? 16'(m_vbase + win * STRIDE) : 16'hFFFF;
    chk("rnd_take", take, exp_take);
    chk("rnd_vec", vec, exp_vec);
    chk("rnd_rdata", rdata, m_rd_exp);

    rv = '0;
    if (sel && re) begin
      case (addr)
        3'd0: rv = m_pend;
        3'd1: rv = m_mask;
        3'd3: for (int k = 0; k < 8; k++) rv = rv | 16'(m_prio[k] << (2 * k));
        3'd4: for (int k = 8; k < 16; k++) rv = rv | 16'(m_prio[k] << (2 * (k - 8)));
        3'd5: rv = m_act;
        3'd6: begin
          d  = m_stk.size();
          rv = 16'(d);
          if (d > 0) rv = rv | 16'(m_stk[d-1].pri << 4) | 16'(m_stk[d-1].idx << 6);
        end
        3'd7: rv = m_vbase;
        default: rv = '0;
      endcase
    end
    m_rd_exp = rv;

    m_pend = now_p;
    if (sel && we && addr == 3'd0) m_pend = m_pend | (wdata & SMASK);
    if (sel && we && addr == 3'd2) m_pend = m_pend & ~wdata;
    if (exp_take) m_pend[win] = 1'b0;
    if (ret_ok) begin
      f = m_stk.pop_back();
      m_act[f.idx] = 1'b0;
    end
    if (exp_take) begin
      m_act[win] = 1'b1;
      m_stk.push_back('{win, wpri});
    end
    if (sel && we && addr == 3'd1) m_mask = wdata & SMASK;
    if (sel && we && addr == 3'd3)
      for (int k = 0; k < 8; k++) if (k < NSRC) m_prio[k] = (wdata >> (2 * k)) & 3;
    if (sel && we && addr == 3'd4)
      for (int k = 8; k < 16; k++) if (k < NSRC) m_prio[k] = (wdata >> (2 * (k - 8))) & 3;
    if (sel && we && addr == 3'd7) m_vbase = wdata;
    m_prev = 16'(src);
  endtask

  initial begin
    tbl[0]  = '{3'd1, 16'hFFFF, 3'd1, 16'h00FF};
    tbl[1]  = '{3'd3, 16'hABCD, 3'd3, 16'hABCD};
    tbl[2]  = '{3'd4, 16'h1234, 3'd4, 16'h0000};
    tbl[3]  = '{3'd7, 16'h1234, 3'd7, 16'h1234};
    tbl[4]  = '{3'd5, 16'hFFFF, 3'd5, 16'h0000};
    tbl[5]  = '{3'd6, 16'hFFFF, 3'd6, 16'h0000};
    tbl[6]  = '{3'd2, 16'hFFFF, 3'd2, 16'h0000};
    tbl[7]  = '{3'd0, 16'h0F0A, 3'd0, 16'h000A};
    tbl[8]  = '{3'd2, 16'h0002, 3'd0, 16'h0008};
    tbl[9]  = '{3'd1, 16'h0000, 3'd1, 16'h0000};
    tbl[10] = '{3'd2, 16'hFFFF, 3'd0, 16'h0000};
    tbl[11] = '{3'd3, 16'h0000, 3'd3, 16'h0000};
    tbl[12] = '{3'd7, 16'h0020, 3'd7, 16'h0020};
    tbl[13] = '{3'd1, 16'h00FF, 3'd1, 16'h00FF};

    rst = 1'b1; sel = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    src = '0; int_en = 1'b0; ret = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_rdy", rdy, 1'b0);
    chk("rst_take", take, 1'b0);
    chk("rst_vec", vec, 16'hFFFF);
    sel = 1'b1; #1; chk("rdy_sel", rdy, 1'b1); sel = 1'b0;
    rd_chk("rst_mask", 3'd1, 16'h00FF);
    rd_chk("rst_status", 3'd6, 16'h0000);
    tick();
    chk("rdata_idle", rdata, 16'h0000);

    // Register table with interrupts globally disabled
    for (int i = 0; i < 14; i++) begin
      mmio_wr(tbl[i].wa, tbl[i].wd);
      rd_chk($sformatf("tbl%0d", i), tbl[i].ra, tbl[i].exp);
      chk($sformatf("tbl%0d_take", i), take, 1'b0);
    end

    // Simultaneous sources at equal priority: higher index first
    int_en = 1'b1;
    src = 8'h24; take_chk("s25", 1'b1, 16'h00C0); tick();
    src = 8'h00; take_chk("s2_wait", 1'b0, 16'hFFFF);
    ret = 1'b1;  take_chk("s2_ret", 1'b1, 16'h0060); tick();
    ret = 1'b0;
    rd_chk("swap_status", 3'd6, 16'h0081);
    rd_chk("swap_active", 3'd5, 16'h0004);
    rd_chk("swap_pend", 3'd0, 16'h0000);
    ret = 1'b1; tick(); ret = 1'b0;
    rd_chk("swap_status0", 3'd6, 16'h0000);

    // Nested preemption by a higher priority source
    mmio_wr(3'd3, 16'h0030);
    src = 8'h02; take_chk("n1", 1'b1, 16'h0040); tick();
    src = 8'h04; take_chk("n2", 1'b1, 16'h0060); tick();
    src = 8'h00;
    rd_chk("n_status", 3'd6, 16'h00B2);
    src = 8'h08; take_chk("n3_block", 1'b0, 16'hFFFF);
    ret = 1'b1;  take_chk("n3_ret1", 1'b0, 16'hFFFF); tick();
    take_chk("n3_ret2", 1'b1, 16'h0080); tick();
    ret = 1'b0; src = 8'h00;
    rd_chk("n3_status", 3'd6, 16'h00C1);
    ret = 1'b1; tick(); ret = 1'b0;

    // Full stack blocks even a higher priority source
    mmio_wr(3'd3, 16'h0309);
    src = 8'h01; take_chk("f1", 1'b1, 16'h0020); tick();
    src = 8'h03; take_chk("f2", 1'b1, 16'h0040); tick();
    src = 8'h13; take_chk("f_full", 1'b0, 16'hFFFF);
    rd_chk("f_status", 3'd6, 16'h0062);
    ret = 1'b1; take_chk("f_ret", 1'b1, 16'h00A0); tick();
    ret = 1'b0; src = 8'h00;
    rd_chk("f_status2", 3'd6, 16'h0132);
    ret = 1'b1; tick(); tick(); ret = 1'b0;
    rd_chk("f_status0", 3'd6, 16'h0000);
    rd_chk("f_pend0", 3'd0, 16'h0000);

    // Reset mid-ISR discards the stack; a following return is ignored
    mmio_wr(3'd3, 16'h0000);
    src = 8'h40; take_chk("r_take", 1'b1, 16'h00E0); tick();
    src = 8'h00; rst = 1'b1; tick(); rst = 1'b0;
    take_chk("r_after", 1'b0, 16'hFFFF);
    ret = 1'b1; tick(); ret = 1'b0;
    rd_chk("r_status", 3'd6, 16'h0000);
    rd_chk("r_active", 3'd5, 16'h0000);

    // Held source across its own return
    src = 8'h01; take_chk("h_take", 1'b1, 16'h0020); tick();
    ret = 1'b1;  take_chk("h_ret", 1'b0, 16'hFFFF); tick();
    ret = 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
    take_chk("h_held", 1'b0, 16'hFFFF); tick();
    take_chk("h_held2", 1'b0, 16'hFFFF);
    src = 8'h00; tick();
    src = 8'h01; take_chk("h_rearm", 1'b1, 16'h0020); tick();
`else
    take_chk("h_repend", 1'b1, 16'h0020); tick();
`endif
    src = 8'h00; ret = 1'b1; tick(); ret = 1'b0;
    rd_chk("h_status0", 3'd6, 16'h0000);

    // Randomized run against the reference model
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    model_reset();
    for (int c = 0; c < 800; c++) begin
      int op;
      src    = NSRC'($urandom & $urandom);
      int_en = ($urandom_range(0, 7) != 0);
      ret    = ($urandom_range(0, 3) == 0);
      sel = 1'b0; we = 1'b0; re = 1'b0;
      addr  = 3'($urandom_range(0, 7));
      wdata = 16'($urandom);
      op = $urandom_range(0, 9);
      if (op < 2) begin
        sel = 1'b1; we = 1'b1;
      end else if (op < 5) begin
        sel = 1'b1; re = 1'b1;
      end
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
